// File: rtl/aes_slot_ram_pkg.sv
// Shared FSM states, record-layout helpers and status markers for the slot RAM
// cipher offload engine.
package aes_slot_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_GATHER = 3'd2,
    S_REQ    = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_MARK   = 3'd6
  } state_e;

  localparam int MARK_W = 256;
  localparam logic [MARK_W-1:0] MARK_DONE = {MARK_W{1'b1}};
  localparam logic [MARK_W-1:0] MARK_BUSY = {MARK_W{1'b0}};

  function automatic int rec_words(input int blk);
    return 2 * blk + 2;
  endfunction

  function automatic int trig_off(input int blk);
    return blk;
  endfunction

  function automatic int res_off(input int blk);
    return blk + 1;
  endfunction

  function automatic int stat_off(input int blk);
    return 2 * blk + 1;
  endfunction

  // Only elaboration-time use: a partial record at the top of memory never triggers.
  function automatic logic is_trig_addr(input int a, input int blk, input int depth);
    int rw;
    rw = rec_words(blk);
    return ((a % rw) == trig_off(blk)) && ((a - trig_off(blk) + rw) <= depth);
  endfunction

endpackage

// File: rtl/aes_slot_ram_if.sv
// Host and cipher-core signal bundle for aes_slot_ram.
interface aes_slot_ram_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int BLK_WORDS = 4
);
  logic                        en;
  logic                        action;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W-1:0]           data_in;
  logic [DATA_W-1:0]           data_out;
  logic                        host_ready;
  logic                        blk_valid;
  logic                        blk_ready;
  logic [BLK_WORDS*DATA_W-1:0] blk_data;
  logic                        res_valid;
  logic [BLK_WORDS*DATA_W-1:0] res_data;
  logic                        done;
  logic                        drop;

  modport master (
    output en, action, addr, data_in, blk_ready, res_valid, res_data,
    input  data_out, host_ready, blk_valid, blk_data, done, drop
  );

  modport slave (
    input  en, action, addr, data_in, blk_ready, res_valid, res_data,
    output data_out, host_ready, blk_valid, blk_data, done, drop
  );
endinterface

// File: rtl/aes_slot_ram_sp_ram.sv
// Single-port word RAM with synchronous read. Host and engine reads land in
// separate output registers so engine traffic never disturbs host read data.
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re_host,
  input  logic              re_eng,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] eng_rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_W-1:0] eng_rdata_q, eng_rdata_d;

  // Read-register next values: load on the matching read strobe, else hold.
  always_comb begin
    host_rdata_d = host_rdata_q;
    eng_rdata_d  = eng_rdata_q;
    if (re_host) begin
      host_rdata_d = mem[addr];
    end else begin
      host_rdata_d = host_rdata_q;
    end
    if (re_eng) begin
      eng_rdata_d = mem[addr];
    end else begin
      eng_rdata_d = eng_rdata_q;
    end
  end

  // Storage array: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata_q <= {DATA_W{1'b0}};
      eng_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      host_rdata_q <= host_rdata_d;
      eng_rdata_q  <= eng_rdata_d;
    end
  end

  assign host_rdata = host_rdata_q;
  assign eng_rdata  = eng_rdata_q;
endmodule

// File: rtl/aes_slot_ram.sv
// Word RAM with a record-based cipher offload engine: a host write to a record's
// trigger word gathers the plaintext, runs it through the cipher core and writes back.
module aes_slot_ram
  import aes_slot_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int BLK_WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  aes_slot_ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BLK_W = BLK_WORDS * DATA_W;
  localparam int CNT_W = $clog2(BLK_WORDS + 1);
  localparam logic [CNT_W-1:0]  BLK_CNT    = CNT_W'(BLK_WORDS);
  localparam logic [ADDR_W-1:0] TRIG_OFF_A = ADDR_W'(trig_off(BLK_WORDS));
  localparam logic [ADDR_W-1:0] RES_OFF_A  = ADDR_W'(res_off(BLK_WORDS));
  localparam logic [ADDR_W-1:0] STAT_OFF_A = ADDR_W'(stat_off(BLK_WORDS));

  function automatic logic [DEPTH-1:0] build_trig_mask();
    logic [DEPTH-1:0] m;
    m = {DEPTH{1'b0}};
    for (int a = 0; a < DEPTH; a++) begin
      m[a] = is_trig_addr(a, BLK_WORDS, DEPTH);
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] TRIG_MASK = build_trig_mask();

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cap_idx_q, cap_idx_d;
  logic               cap_vld_q, cap_vld_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]   res_q, res_d;
  logic               host_ready_q, host_ready_d;
  logic               blk_valid_q, blk_valid_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic [DEPTH-1:0]   trig_map_q, trig_map_d;

  logic               host_acc_s, host_wr_s, host_rd_s, trig_hit_s;
  logic               we_raw_s, re_host_raw_s, re_eng_raw_s;
  logic               ram_we_s, ram_re_host_s, ram_re_eng_s;
  logic [ADDR_W-1:0]  ram_addr_s;
  logic [DATA_W-1:0]  ram_wdata_s;
  logic [DATA_W-1:0]  host_rdata_s, eng_rdata_s;

  assign host_acc_s = bus.en && host_ready_q;
  assign host_wr_s  = host_acc_s && bus.action;
  assign host_rd_s  = host_acc_s && !bus.action;
  // Trigger decode is a registered per-address lookup, loaded on reset.
  assign trig_hit_s = host_wr_s && trig_map_q[bus.addr];

  // Reset suppresses every RAM access in its cycle, so an aborted job stops writing at once.
  assign ram_we_s      = we_raw_s && !rst;
  assign ram_re_host_s = re_host_raw_s && !rst;
  assign ram_re_eng_s  = re_eng_raw_s && !rst;

  // Engine FSM next state, RAM port mux and block capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_idx_d     = cap_idx_q;
    cap_vld_d     = 1'b0;
    base_d        = base_q;
    blk_d         = blk_q;
    res_d         = res_q;
    done_d        = 1'b0;
    drop_d        = 1'b0;
    trig_map_d    = trig_map_q;
    we_raw_s      = host_wr_s;
    re_host_raw_s = host_rd_s;
    re_eng_raw_s  = 1'b0;
    ram_addr_s    = bus.addr;
    ram_wdata_s   = bus.data_in;

    if (cap_vld_q) begin
      blk_d[int'(cap_idx_q)*DATA_W +: DATA_W] = eng_rdata_s;
    end else begin
      blk_d = blk_q;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_hit_s) begin
          state_d = S_CLR;
          base_d  = bus.addr - TRIG_OFF_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        we_raw_s      = 1'b1;
        re_host_raw_s = 1'b0;
        ram_addr_s    = base_q + STAT_OFF_A;
        ram_wdata_s   = MARK_BUSY[DATA_W-1:0];
        cnt_d         = {CNT_W{1'b0}};
        state_d       = S_GATHER;
      end
      S_GATHER: begin
        we_raw_s      = 1'b0;
        re_host_raw_s = 1'b0;
        ram_addr_s    = base_q + ADDR_W'(cnt_q);
        // One extra cycle after the last read lets its word be captured.
        if (cnt_q < BLK_CNT) begin
          re_eng_raw_s = 1'b1;
          cap_vld_d    = 1'b1;
          cap_idx_d    = cnt_q;
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        drop_d = trig_hit_s;
        if (bus.blk_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        drop_d = trig_hit_s;
        if (bus.res_valid) begin
          res_d   = bus.res_data;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WB;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WB: begin
        we_raw_s      = 1'b1;
        re_host_raw_s = 1'b0;
        ram_addr_s    = base_q + RES_OFF_A + ADDR_W'(cnt_q);
        ram_wdata_s   = res_q[int'(cnt_q)*DATA_W +: DATA_W];
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == BLK_CNT - CNT_W'(1)) begin
          state_d = S_MARK;
        end else begin
          state_d = S_WB;
        end
      end
      S_MARK: begin
        we_raw_s      = 1'b1;
        re_host_raw_s = 1'b0;
        ram_addr_s    = base_q + STAT_OFF_A;
        ram_wdata_s   = MARK_DONE[DATA_W-1:0];
        done_d        = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        we_raw_s      = 1'b0;
        re_host_raw_s = 1'b0;
        state_d       = S_IDLE;
      end
    endcase

    host_ready_d = (state_d == S_IDLE) || (state_d == S_REQ) || (state_d == S_WAIT);
    blk_valid_d  = (state_d == S_REQ);
  end

  // Engine and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      cap_idx_q    <= {CNT_W{1'b0}};
      cap_vld_q    <= 1'b0;
      base_q       <= {ADDR_W{1'b0}};
      blk_q        <= {BLK_W{1'b0}};
      res_q        <= {BLK_W{1'b0}};
      host_ready_q <= 1'b1;
      blk_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      trig_map_q   <= TRIG_MASK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_idx_q    <= cap_idx_d;
      cap_vld_q    <= cap_vld_d;
      base_q       <= base_d;
      blk_q        <= blk_d;
      res_q        <= res_d;
      host_ready_q <= host_ready_d;
      blk_valid_q  <= blk_valid_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      trig_map_q   <= trig_map_d;
    end
  end

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we         (ram_we_s),
    .re_host    (ram_re_host_s),
    .re_eng     (ram_re_eng_s),
    .addr       (ram_addr_s),
    .wdata      (ram_wdata_s),
    .host_rdata (host_rdata_s),
    .eng_rdata  (eng_rdata_s)
  );

  assign bus.data_out   = host_rdata_s;
  assign bus.host_ready = host_ready_q;
  assign bus.blk_valid  = blk_valid_q;
  assign bus.blk_data   = blk_q;
  assign bus.done       = done_q;
  assign bus.drop       = drop_q;
endmodule

// File: tb/tb_aes_slot_ram.sv
// Self-checking bench for aes_slot_ram: storage table, three cipher jobs
// (stalled, zero-wait, reset during write-back) and busy-trigger drop.
module tb_aes_slot_ram;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int N      = 4;
  localparam int BW     = N * DATA_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   drop_cnt = 0;
  logic [DATA_W-1:0] model [1 << ADDR_W];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  aes_slot_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_WORDS(N)) bus ();

  aes_slot_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_WORDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.drop === 1'b1) drop_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.blk_valid;
      1:       return bus.done;
      default: return bus.host_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name, output int cyc);
    cyc = 0;
    while (sig(which) !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    if (sig(which) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: still low after %0d cycles, required high", name, cyc);
    end
  endtask

  task automatic hwrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int cyc;
    wait_sig(2, "host_ready_wr", cyc);
    bus.en = 1'b1; bus.action = 1'b1; bus.addr = a; bus.data_in = d;
    step();
    bus.en = 1'b0; bus.action = 1'b0;
    model[a] = d;
  endtask

  task automatic hread(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    exp_t e;
    int   cyc;
    wait_sig(2, "host_ready_rd", cyc);
    e.name = $sformatf("read_addr_%0d", a);
    e.val  = exp;
    exp_q.push_back(e);
    bus.en = 1'b1; bus.action = 1'b0; bus.addr = a;
    step();
    bus.en = 1'b0;
    e = exp_q.pop_front();
    check(e.name, BW'(bus.data_out), BW'(e.val));
  endtask

  function automatic logic [BW-1:0] exp_blk(input int base);
    logic [BW-1:0] b;
    for (int i = 0; i < N; i++) b[i*DATA_W +: DATA_W] = model[base + i];
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [12];
    logic [BW-1:0] blk_ref;
    logic [BW-1:0] res_v;
    int            c1, c2;

    tbl[0]  = '{7'd0,   32'hDEAD_BEEF, 32'h0000_0011};
    tbl[1]  = '{7'd1,   32'h0000_0022, 32'h0000_0022};
    tbl[2]  = '{7'd2,   32'h0000_0033, 32'h0000_0033};
    tbl[3]  = '{7'd3,   32'h0000_0044, 32'h0000_0044};
    tbl[4]  = '{7'd0,   32'h0000_0011, 32'h0000_0011};
    tbl[5]  = '{7'd10,  32'h1010_AAAA, 32'h1010_AAAA};
    tbl[6]  = '{7'd11,  32'h1111_BBBB, 32'h1111_BBBB};
    tbl[7]  = '{7'd12,  32'h1212_CCCC, 32'h1212_CCCC};
    tbl[8]  = '{7'd13,  32'h1313_DDDD, 32'h1313_DDDD};
    tbl[9]  = '{7'd120, 32'h7E57_0120, 32'h7E57_0120};
    tbl[10] = '{7'd124, 32'h7E57_0124, 32'h7E57_0124};
    tbl[11] = '{7'd127, 32'h7E57_0127, 32'h7E57_0127};

    bus.en = 1'b0; bus.action = 1'b0; bus.addr = '0; bus.data_in = '0;
    bus.blk_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    check("rst_data_out", BW'(bus.data_out), '0);
    check("rst_host_ready", BW'(bus.host_ready), BW'(1));
    check("rst_blk_valid", BW'(bus.blk_valid), '0);
    check("rst_blk_data", bus.blk_data, '0);
    check("rst_done_drop", BW'({bus.done, bus.drop}), '0);

    // Read of addr 3 before anything was written: data_out stays 0 until the edge.
    bus.en = 1'b1; bus.action = 1'b0; bus.addr = 7'd3;
    #3;
    check("rd3_pending_data_out", BW'(bus.data_out), '0);
    step();
    bus.en = 1'b0;

    // Plain storage, including the tail region that must never start a job.
    for (int i = 0; i < 12; i++) begin
      hwrite(tbl[i].addr, tbl[i].wdata);
      check($sformatf("no_job_after_wr_%0d", tbl[i].addr), BW'(bus.host_ready), BW'(1));
    end
    for (int i = 0; i < 12; i++) hread(tbl[i].addr, tbl[i].exp);
    check("tail_no_done_drop", BW'(done_cnt + drop_cnt), '0);

    // res_valid outside WAIT is ignored.
    bus.res_valid = 1'b1; step(); bus.res_valid = 1'b0; step();
    check("stray_res_valid", BW'({bus.host_ready, bus.done}), BW'(2'b10));

    // Job 1: record 0, 20-cycle stall, busy trigger on record 1 while in WAIT.
    hwrite(7'd4, 32'h0000_0004);
    check("clr_host_ready_low", BW'(bus.host_ready), '0);
    wait_sig(0, "blk_valid_job1", c1);
    check("job1_valid_latency", BW'(c1), BW'(N + 2));
    blk_ref = exp_blk(0);
    check("job1_blk_data", bus.blk_data, {32'h44, 32'h33, 32'h22, 32'h11});
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) hread(7'd2, model[2]);
      else step();
      check($sformatf("stall_valid_%0d", i), BW'(bus.blk_valid), BW'(1));
      check($sformatf("stall_data_%0d", i), bus.blk_data, blk_ref);
    end
    bus.blk_ready = 1'b1; step(); bus.blk_ready = 1'b0;
    check("hs_valid_low", BW'(bus.blk_valid), '0);
    hwrite(7'd14, 32'hABCD_0014);
    check("busy_drop_pulse", BW'(bus.drop), BW'(1));
    res_v = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    bus.res_valid = 1'b1; bus.res_data = res_v;
    step();
    bus.res_valid = 1'b0;
    check("drop_one_cycle", BW'(bus.drop), '0);
    wait_sig(1, "done_job1", c2);
    check("job1_done_latency", BW'(c2), BW'(N + 1));
    check("job1_done_host_ready", BW'(bus.host_ready), BW'(1));
    for (int i = 0; i < N; i++) model[5 + i] = res_v[i*DATA_W +: DATA_W];
    model[9] = 32'hFFFF_FFFF;
    step();
    check("done_one_cycle", BW'(bus.done), '0);
    hread(7'd5, 32'hA1); hread(7'd6, 32'hB2); hread(7'd7, 32'hC3); hread(7'd8, 32'hD4);
    hread(7'd9, 32'hFFFF_FFFF);
    hread(7'd14, 32'hABCD_0014);
    hread(7'd0, 32'h11);
    check("job1_done_count", BW'(done_cnt), BW'(1));
    check("job1_drop_count", BW'(drop_cnt), BW'(1));

    // Job 2: record 1 with a zero-wait cipher gives the minimum job length.
    hwrite(7'd14, 32'h0000_000E);
    bus.blk_ready = 1'b1;
    wait_sig(0, "blk_valid_job2", c1);
    check("job2_valid_latency", BW'(c1), BW'(N + 2));
    check("job2_blk_data", bus.blk_data, exp_blk(10));
    step();
    bus.blk_ready = 1'b0;
    res_v = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
    bus.res_valid = 1'b1; bus.res_data = res_v;
    step();
    bus.res_valid = 1'b0;
    wait_sig(1, "done_job2", c2);
    check("job2_min_length", BW'(c1 + 2 + c2), BW'(2 * N + 5));
    for (int i = 0; i < N; i++) model[15 + i] = res_v[i*DATA_W +: DATA_W];
    model[19] = 32'hFFFF_FFFF;
    hread(7'd15, model[15]); hread(7'd18, model[18]); hread(7'd19, model[19]);
    hread(7'd13, 32'h1313_DDDD);

    // Job 3: record 0 again, reset lands after two result words are written.
    hwrite(7'd4, 32'h0000_0044);
    bus.blk_ready = 1'b1;
    wait_sig(0, "blk_valid_job3", c1);
    step();
    bus.blk_ready = 1'b0;
    res_v = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    bus.res_valid = 1'b1; bus.res_data = res_v;
    step();
    bus.res_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midjob_rst_host_ready", BW'(bus.host_ready), BW'(1));
    check("midjob_rst_blk_valid", BW'(bus.blk_valid), '0);
    check("midjob_rst_blk_data", bus.blk_data, '0);
    check("midjob_rst_data_out", BW'(bus.data_out), '0);
    model[5] = 32'h3333_0001;
    model[6] = 32'h3333_0002;
    model[9] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) step();
    hread(7'd5, 32'h3333_0001); hread(7'd6, 32'h3333_0002);
    hread(7'd7, 32'hC3); hread(7'd8, 32'hD4);
    hread(7'd9, 32'h0000_0000);
    check("midjob_done_count", BW'(done_cnt), BW'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_slot_ram.md
# aes_slot_ram

Parametrised single-port word RAM with an integrated block-cipher offload engine, successor to the fixed 128x32 AES buffer. Host writes plaintext words into fixed-size records; a write to a record's trigger word starts a job. An internal FSM gathers the block, hands it to an external cipher core over a valid/ready handshake, writes the result back into the record, then stamps a status marker. It sits between the RS-232 command decoder (host port) and the AES core (cipher port).

## Interface
- `DATA_W`, 32: word width.
- `ADDR_W`, 7: address width; depth = 2**ADDR_W.
- `BLK_WORDS`, 4: words per cipher block; block width = BLK_WORDS*DATA_W.
- Derived `REC_WORDS` = 2*BLK_WORDS+2 (10 at defaults): record stride.
- `clk` in 1: sole clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: host access request.
- `action` in 1: 1 = write, 0 = read.
- `addr` in ADDR_W: host word address.
- `data_in` in DATA_W: host write data.
- `data_out` out DATA_W: host read data, registered.
- `host_ready` out 1: host access accepted this cycle when `en && host_ready`.
- `blk_valid` out 1: block offered to cipher core.
- `blk_ready` in 1: cipher core accepts block.
- `blk_data` out BLK_WORDS*DATA_W: word at record offset i in bits [i*DATA_W +: DATA_W].
- `res_valid` in 1: cipher result present, one-cycle pulse.
- `res_data` in BLK_WORDS*DATA_W: result, same packing.
- `done` out 1: one-cycle pulse, job complete.
- `drop` out 1: one-cycle pulse, trigger ignored because engine busy.

## Operation
- Record k occupies base B = k*REC_WORDS. Offsets 0..BLK_WORDS-1 hold plaintext. Offset BLK_WORDS is the trigger. Offsets BLK_WORDS+1..2*BLK_WORDS hold the result. Offset 2*BLK_WORDS+1 is status.
- Only complete records count: B+REC_WORDS <= 2**ADDR_W. Tail words (120..127 at defaults) are plain storage and never trigger.
- Accepted host write stores `data_in`. Accepted read updates `data_out` on the next edge.
- Trigger = accepted write to a trigger offset. In IDLE it starts a job, and the write itself is still stored. Outside IDLE the write is stored, no job starts, and `drop` pulses.
- FSM states:
  - IDLE
  - CLR: write status = 0.
  - GATHER: issue BLK_WORDS reads at offsets 0..N-1; each word is captured one cycle after its read is issued.
  - REQ: `blk_valid`=1, held with `blk_data` stable until `blk_ready`.
  - WAIT: wait for `res_valid`, capture `res_data`.
  - WB: one write per cycle to offsets BLK_WORDS+1.., low word first.
  - MARK: write status = all ones, pulse `done`, return to IDLE.
- `host_ready` = 1 in IDLE, REQ and WAIT; 0 in CLR, GATHER, WB and MARK, where the engine owns the port.
- Host writes to the active record during REQ/WAIT are allowed and do not alter the captured block. Such writes to the result or status offsets are later overwritten by WB/MARK.
- `res_valid` outside WAIT is ignored. `blk_ready` outside REQ is ignored.
- Reset mid-job: immediate return to IDLE on the next edge. Outputs drop to reset values and no further engine writes occur. Record contents are left as they were, status word included.
- Reset values: `data_out`=0, `host_ready`=1, `blk_valid`=0, `blk_data`=0, `done`=0, `drop`=0, state IDLE. RAM contents are not reset.

## Timing
- Host read latency: 1 cycle.
- Trigger write at edge E0: status cleared at E1, GATHER reads at E2..E(N+1), `blk_valid` high from E(N+2). N = BLK_WORDS.
- Handshake completes on the edge where `blk_valid && blk_ready`; `blk_valid` is low after that edge.
- `res_valid` sampled at edge Ew: result writes at Ew+1..Ew+N, marker at Ew+N+1. `done` is high in the cycle after Ew+N+1, and `host_ready` returns high in that same cycle.
- Minimum job: 2N+5 cycles with zero-wait cipher.
- Trigger address detection uses a registered record-offset comparison, not a combinational modulo on `addr`.

## Structure
- Package `aes_slot_pkg`:
  - state enum;
  - offset helper functions (REC_WORDS, trigger/result/status offsets);
  - MARK_DONE constant (all ones) and MARK_BUSY constant (0).
- One sub-module `sp_ram` (single-port, DATA_W x 2**ADDR_W, 1-cycle read).
- FSM, port mux and trigger detect live in the top level.

## Test plan
- Reset, then read addr 3 → `data_out`=0 until read completes; `host_ready`=1, `blk_valid`=0.
- Write 0x11,0x22,0x33,0x44 to addr 0..3, then trigger addr 4; cipher returns {0xD4,0xC3,0xB2,0xA1} one cycle after handshake. Required: `blk_data`={0x44,0x33,0x22,0x11} (high to low); addr 5..8 read 0xA1,0xB2,0xC3,0xD4; addr 9 reads 0xFFFFFFFF; `done` pulses once.
- Hold `blk_ready`=0 for 20 cycles → `blk_valid` and `blk_data` stable throughout; host reads of addr 2 succeed during the stall.
- Trigger record 1 (addr 14) while job on record 0 is in WAIT → `drop` pulses, addr 14 holds written data, only one `done`.
- Write addr 124 (tail region) → no job, no `drop`; status word at addr 129 is out of range, so no write.
- Assert `rst` during WB after 2 result words → no further writes; addr 5,6 updated, addr 7,8 old values, addr 9 = 0.
